adder_result_packer: RTL

ADDER_RESULT_PACKER -- requirements
Module: adder_result_packer

---
 rtl/adder_result_packer_pkg.sv | 23 ++
 rtl/adder_result_packer_fp_pack_word.sv | 26 ++
 rtl/adder_result_packer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adder_result_packer_pkg.sv
// Shared constants, state encoding and the stored-entry layout for the result packer.
// Used by the packing sub-module and the skid-buffered top.
package adder_result_packer_pkg;

  localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_ONES  = 8'hFF;
  localparam logic [7:0]  EXP_ZERO  = 8'h00;

  // Flag vector layout: {invalid, overflow, underflow}
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  flags;
  } entry_t;

endpackage

// File: rtl/adder_result_packer_fp_pack_word.sv
// Combinational IEEE-754 single packing with invalid > overflow > underflow > normal priority.
// Zero latency; no flow control of its own.
module fp_pack_word
  import adder_result_packer_pkg::*;
#(
  parameter bit QNAN_CANON = 1'b1
) (
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [22:0] mant,
  input  logic [2:0]  flags,
  output logic [31:0] word
);

  always_comb begin
    word = {sign, exp, mant};
    if (flags[FLAG_INV]) begin
      word = QNAN_CANON ? QNAN_WORD : {sign, EXP_ONES, mant};
    end else if (flags[FLAG_OVF]) begin
      word = {sign, EXP_ONES, 23'h0};
    end else if (flags[FLAG_UNF]) begin
      word = {sign, EXP_ZERO, mant};
    end
  end

endmodule

// File: rtl/adder_result_packer.sv
// Packs adder results into IEEE-754 words behind a two-entry skid buffer; accept-to-out_valid is one cycle.
// in_ready is registered and drops only when both entries are held; output holds steady under out_ready=0.
module adder_result_packer
  import adder_result_packer_pkg::*;
#(
  parameter bit QNAN_CANON = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [22:0] in_mant,
  input  logic [7:0]  in_exp,
  input  logic        in_overflow,
  input  logic        in_underflow,
  input  logic        in_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [2:0]  sticky_flags,
  input  logic        flags_clear,
  output logic [15:0] result_count
);

  logic [1:0]  state_q, state_d;
  logic        in_ready_q;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  entry_t      in_entry;
  logic [2:0]  in_flags;
  logic [31:0] in_word;
  logic [2:0]  sticky_q;
  logic [15:0] count_q;
  logic        accept, deliver;

  assign in_flags = {in_invalid, in_overflow, in_underflow};

  fp_pack_word #(
    .QNAN_CANON (QNAN_CANON)
  ) u_pack (
    .sign  (in_sign),
    .exp   (in_exp),
    .mant  (in_mant),
    .flags (in_flags),
    .word  (in_word)
  );

  assign in_entry = '{word: in_word, flags: in_flags};

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign out_result   = out_q.word;
  assign out_flags    = out_q.flags;
  assign sticky_flags = sticky_q;
  assign result_count = count_q;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          out_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = ST_TWO;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the skid promotion can happen
        if (deliver) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  // A delivery in the clearing cycle still lands in the sticky set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sticky_q <= (flags_clear ? 3'b000 : sticky_q) | (deliver ? out_q.flags : 3'b000);
      if (deliver) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule
